// File: rtl/fft8_bf_sched_if.sv
// Handshake bundle between FFT control, the butterfly scheduler and the butterfly unit.
// The slave side is the scheduler; the master side is the controller or bench driving it.
interface fft8_bf_sched_if;
    logic        start;
    logic        wb_valid;
    logic        busy;
    logic        done;
    logic        issue;
    logic [2:0]  a_now;
    logic [2:0]  b_now;
    logic [31:0] w_re;
    logic [31:0] w_im;
    logic        is_mj;
    logic [1:0]  stage;
    logic        err;

    modport master (
        output start, wb_valid,
        input  busy, done, issue, a_now, b_now, w_re, w_im, is_mj, stage, err
    );

    modport slave (
        input  start, wb_valid,
        output busy, done, issue, a_now, b_now, w_re, w_im, is_mj, stage, err
    );
endinterface

// File: rtl/fft8_bf_sched.sv
// Stage/butterfly scheduler for the shared butterfly of the 8-point radix-2 DIT FFT.
// Issues 3 stages x 4 butterflies, gating each stage on 4 writebacks of the previous one.
module fft8_bf_sched #(
    parameter int L_MUL   = 3,
    parameter int L_ADD   = 2,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst_n,
    fft8_bf_sched_if.slave bus
);
    localparam int DW = $clog2(TIMEOUT + 1);

    if (L_MUL < 1 || L_ADD < 1 || TIMEOUT < 1) begin : g_param_check
        $error("fft8_bf_sched: L_MUL, L_ADD and TIMEOUT must all be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    stage_q, stage_d;
    logic [1:0]    j_q, j_d;
    logic [2:0]    wb_cnt_q, wb_cnt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          err_q, err_d;

    logic          busy_q, busy_d, done_q, done_d, issue_q, issue_d, is_mj_q, is_mj_d;
    logic [2:0]    a_q, a_d, b_q, b_d;
    logic [31:0]   w_re_q, w_re_d, w_im_q, w_im_d;
    logic [1:0]    stage_o_q, stage_o_d;
    logic [1:0]    tw_d;
    logic [63:0]   w_d;

    function automatic logic [2:0] addr_a(input logic [1:0] s, input logic [1:0] j);
        logic [2:0] half, k, grp;
        half = 3'd1 << s;
        k    = {1'b0, j} & (half - 3'd1);
        grp  = {1'b0, j} >> s;
        return (grp << (s + 2'd1)) | k;
    endfunction

    function automatic logic [1:0] tw_idx(input logic [1:0] s, input logic [1:0] j);
        logic [1:0] k;
        k = j & ((2'd1 << s) - 2'd1);
        return k << (2'd2 - s);
    endfunction

    // W8^tw in IEEE-754 single precision, {re, im}
    function automatic logic [63:0] twiddle(input logic [1:0] tw);
        case (tw)
            2'd0:    return {32'h3F80_0000, 32'h0000_0000};
            2'd1:    return {32'h3F35_04F3, 32'hBF35_04F3};
            2'd2:    return {32'h0000_0000, 32'hBF80_0000};
            default: return {32'hBF35_04F3, 32'hBF35_04F3};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stage_q   <= 2'd0;
            j_q       <= 2'd0;
            wb_cnt_q  <= 3'd0;
            drain_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            issue_q   <= 1'b0;
            a_q       <= 3'd0;
            b_q       <= 3'd0;
            w_re_q    <= 32'd0;
            w_im_q    <= 32'd0;
            is_mj_q   <= 1'b0;
            stage_o_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            j_q       <= j_d;
            wb_cnt_q  <= wb_cnt_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            issue_q   <= issue_d;
            a_q       <= a_d;
            b_q       <= b_d;
            w_re_q    <= w_re_d;
            w_im_q    <= w_im_d;
            is_mj_q   <= is_mj_d;
            stage_o_q <= stage_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        j_d      = j_q;
        wb_cnt_d = wb_cnt_q;
        drain_d  = drain_q;
        err_d    = err_q;

        // Writebacks are counted first so a same-cycle strobe can complete the stage.
        if (state_q != S_IDLE && bus.wb_valid) begin
            if (wb_cnt_q == 3'd4) err_d = 1'b1;
            else                  wb_cnt_d = wb_cnt_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.wb_valid) err_d = 1'b1;
                if (bus.start) begin
                    state_d  = S_ISSUE;
                    stage_d  = 2'd0;
                    j_d      = 2'd0;
                    wb_cnt_d = 3'd0;
                    err_d    = 1'b0;
                end
            end
            S_ISSUE: begin
                if (j_q == 2'd3) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (wb_cnt_d == 3'd4) begin
                    if (stage_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                        stage_d  = stage_q + 2'd1;
                        j_d      = 2'd0;
                        wb_cnt_d = 3'd0;
                    end
                end else if (drain_q == DW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                stage_d = 2'd0;
            end
        endcase
    end

    // Outputs are derived from the next state so the registered bus lines up with it.
    always_comb begin
        issue_d   = (state_d == S_ISSUE);
        busy_d    = issue_d || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        stage_o_d = busy_d ? stage_d : 2'd0;
        tw_d      = tw_idx(stage_d, j_d);
        w_d       = twiddle(tw_d);
        a_d       = 3'd0;
        b_d       = 3'd0;
        w_re_d    = 32'd0;
        w_im_d    = 32'd0;
        is_mj_d   = 1'b0;
        if (issue_d) begin
            a_d     = addr_a(stage_d, j_d);
            b_d     = addr_a(stage_d, j_d) + (3'd1 << stage_d);
            w_re_d  = w_d[63:32];
            w_im_d  = w_d[31:0];
            is_mj_d = (tw_d == 2'd2);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.issue = issue_q;
    assign bus.a_now = a_q;
    assign bus.b_now = b_q;
    assign bus.w_re  = w_re_q;
    assign bus.w_im  = w_im_q;
    assign bus.is_mj = is_mj_q;
    assign bus.stage = stage_o_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_fft8_bf_sched.sv
// Self-checking bench for fft8_bf_sched: open-loop butterfly writeback schedule plus a
// per-run expected-waveform model built from the stage tables and latency rules.
module tb_fft8_bf_sched;
    localparam int L_MUL   = 3;
    localparam int L_ADD   = 2;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 1 + L_MUL + 2 * L_ADD;
    localparam int NW      = 160;

    localparam int A_TAB  [0:2][0:3] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    localparam int B_TAB  [0:2][0:3] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    localparam int TW_TAB [0:2][0:3] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};
    localparam logic [31:0] W_RE [0:3] = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3};
    localparam logic [31:0] W_IM [0:3] = '{32'h00000000, 32'hBF3504F3, 32'hBF800000, 32'hBF3504F3};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft8_bf_sched_if bus ();

    fft8_bf_sched #(.L_MUL(L_MUL), .L_ADD(L_ADD), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int T     = 0;
    int g_done;
    bit run_active = 1'b0;

    bit          e_start [NW];
    bit          e_wb    [NW];
    bit          e_issue [NW];
    bit          e_busy  [NW];
    bit          e_done  [NW];
    bit          e_mj    [NW];
    bit          e_err   [NW];
    logic [2:0]  e_a     [NW];
    logic [2:0]  e_b     [NW];
    logic [31:0] e_wre   [NW];
    logic [31:0] e_wim   [NW];
    logic [1:0]  e_stage [NW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int r);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at rel cycle %0d: got %h, expected %h", nm, r, act, exp);
        end
    endtask

    task automatic chk_zero(input int tag);
        chk("zero_busy",  32'(bus.busy),  0, tag);
        chk("zero_done",  32'(bus.done),  0, tag);
        chk("zero_issue", 32'(bus.issue), 0, tag);
        chk("zero_a",     32'(bus.a_now), 0, tag);
        chk("zero_b",     32'(bus.b_now), 0, tag);
        chk("zero_wre",   bus.w_re,       0, tag);
        chk("zero_wim",   bus.w_im,       0, tag);
        chk("zero_mj",    32'(bus.is_mj), 0, tag);
        chk("zero_stage", 32'(bus.stage), 0, tag);
        chk("zero_err",   32'(bus.err),   0, tag);
    endtask

    // Expected waveform relative to the start cycle (r=0 is the cycle start is high).
    task automatic build(input int stall, input bit drop, input bit err_in, input bit extras);
        int is_, nxt, nwb, t, tw, done_r;
        bit tmo;
        for (int r = 0; r < NW; r++) begin
            e_start[r] = 0; e_wb[r] = 0; e_issue[r] = 0; e_busy[r] = 0; e_done[r] = 0;
            e_mj[r] = 0; e_err[r] = 0; e_a[r] = 0; e_b[r] = 0; e_wre[r] = 0; e_wim[r] = 0;
            e_stage[r] = 0;
        end
        e_start[0] = 1;
        is_ = 1; done_r = 0; tmo = 0;
        for (int s = 0; s < 3; s++) begin
            nxt = is_ + 5;
            nwb = 0;
            for (int j = 0; j < 4; j++) begin
                tw = TW_TAB[s][j];
                e_issue[is_+j] = 1;
                e_a[is_+j]     = 3'(A_TAB[s][j]);
                e_b[is_+j]     = 3'(B_TAB[s][j]);
                e_wre[is_+j]   = W_RE[tw];
                e_wim[is_+j]   = W_IM[tw];
                e_mj[is_+j]    = (tw == 2);
                if (!(drop && s == 0 && j == 3)) begin
                    t = is_ + j + LAT + ((s == 1 && j == 3) ? stall : 0);
                    e_wb[t] = 1;
                    nwb++;
                    if (t + 1 > nxt) nxt = t + 1;
                end
            end
            if (nwb < 4 || nxt - 1 > is_ + 3 + TIMEOUT) begin
                tmo = 1;
                done_r = is_ + 4 + TIMEOUT;
                break;
            end
            for (int r = is_; r < nxt; r++) e_stage[r] = 2'(s);
            if (s == 2) done_r = nxt;
            else        is_ = nxt;
        end
        for (int r = 1; r < done_r; r++) e_busy[r] = 1;
        e_done[done_r] = 1;
        e_err[0] = err_in;
        if (tmo) for (int r = done_r; r < NW; r++) e_err[r] = 1;
        if (extras) begin
            e_start[5] = 1;
            e_start[done_r] = 1;
            e_wb[done_r+3] = 1;
            for (int r = done_r + 4; r < NW; r++) e_err[r] = 1;
        end
        g_done = done_r;
    endtask

    task automatic do_run(input int stall, input bit drop, input bit err_in, input bit extras, input int lim);
        int n;
        build(stall, drop, err_in, extras);
        n = (lim > 0) ? lim : g_done + (extras ? 8 : 4);
        @(posedge clk);
        #1;
        T = cyc + 1;
        run_active = 1;
        while (cyc < T + n) begin
            @(posedge clk);
            #1;
        end
        run_active = 0;
    endtask

    // Input driver: plays the scheduled start/wb_valid pattern.
    int dr;
    initial begin
        bus.start = 0;
        bus.wb_valid = 0;
        forever begin
            @(negedge clk);
            dr = cyc - T;
            if (run_active && dr >= 0 && dr < NW) begin
                bus.start    = e_start[dr];
                bus.wb_valid = e_wb[dr];
            end else begin
                bus.start    = 0;
                bus.wb_valid = 0;
            end
        end
    end

    // Compare process: every output, every cycle of an active run.
    int cr;
    initial forever begin
        @(negedge clk);
        cr = cyc - T;
        if (run_active && cr >= 0 && cr < NW) begin
            chk("issue", 32'(bus.issue), 32'(e_issue[cr]), cr);
            chk("busy",  32'(bus.busy),  32'(e_busy[cr]),  cr);
            chk("done",  32'(bus.done),  32'(e_done[cr]),  cr);
            chk("a_now", 32'(bus.a_now), 32'(e_a[cr]),     cr);
            chk("b_now", 32'(bus.b_now), 32'(e_b[cr]),     cr);
            chk("w_re",  bus.w_re,       e_wre[cr],        cr);
            chk("w_im",  bus.w_im,       e_wim[cr],        cr);
            chk("is_mj", 32'(bus.is_mj), 32'(e_mj[cr]),    cr);
            chk("stage", 32'(bus.stage), 32'(e_stage[cr]), cr);
            chk("err",   32'(bus.err),   32'(e_err[cr]),   cr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mj_cnt;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(-1);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk_zero(-2);

        // Nominal transform, then pin the model to hand-derived numbers.
        do_run(0, 0, 0, 0, 0);
        mj_cnt = 0;
        for (int r = 0; r < NW; r++) if (e_mj[r]) mj_cnt++;
        chk("pin_done_cycle", 32'(g_done), 37, 0);
        chk("pin_s1_first", 32'(e_issue[13]), 1, 13);
        chk("pin_s1_gap",   32'(e_issue[12]), 0, 12);
        chk("pin_s2_b",     32'(e_b[25]), 4, 25);
        chk("pin_s2_j1_re", e_wre[26], 32'h3F3504F3, 26);
        chk("pin_mj_count", 32'(mj_cnt), 3, 0);

        do_run(0, 0, 0, 1, 0);   // ignored starts at r=5 and in DONE, spurious wb in IDLE
        do_run(20, 0, 1, 0, 0);  // stage-1 4th writeback stalled by 20 cycles
        do_run(0, 1, 0, 0, 0);   // stage-0 4th writeback lost -> timeout
        chk("pin_timeout_done", 32'(g_done), 69, 0);
        do_run(0, 0, 1, 0, 0);   // next start clears err

        // Abort during stage-1 issue, then a clean run.
        do_run(0, 0, 0, 0, 15);
        #2;
        rst_n = 0;
        #1;
        chk_zero(-3);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk_zero(-4);
        do_run(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fft8_bf_sched.md
Name: fft8_bf_sched

Overview:
Stage/butterfly scheduler for the single shared floating-point butterfly unit of the 8-point radix-2 DIT FFT. On start, it sequences 3 stages × 4 butterflies into the butterfly unit. For each butterfly it drives the issue strobe, operand addresses, twiddle constants and the is_mj flag. It counts writebacks so that a stage never issues before the previous stage's results are in memory, then pulses done. It sits between the FFT top-level control and the butterfly unit; the data memory reads its A/B ports combinationally from a_now/b_now.

Parameters:
L_MUL, 3, multiplier latency of the butterfly datapath (must be ≥1)
L_ADD, 2, adder latency of the butterfly datapath (must be ≥1)
TIMEOUT, 64, maximum cycles allowed in DRAIN before the error flag sets

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one full 8-point transform
wb_valid  in  1  writeback strobe returned by the butterfly unit
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when stage 2's 4th writeback has been received
issue  out  1  butterfly issue strobe
a_now  out  3  butterfly operand A address
b_now  out  3  butterfly operand B address
w_re  out  32  twiddle real part, IEEE-754 single precision
w_im  out  32  twiddle imaginary part, IEEE-754 single precision
is_mj  out  1  high when the twiddle equals −j (tw index 2)
stage  out  2  current stage 0..2 (0 when idle)
err  out  1  sticky error; cleared by the next accepted start

Behaviour:
- Clock, reset and reset values:
  - One clock: clk. Reset rst_n is asynchronous and active-low.
  - On reset, all outputs are 0 and the FSM is in IDLE.
  - All outputs are registered.
  - issue, a_now, b_now, w_re, w_im and is_mj change together in the same cycle.
- State machine: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 → ISSUE. Stage and butterfly index j are set to 0, the writeback counter and err are cleared, and busy=1 from the next cycle.
  - ISSUE: issue=1 for exactly 4 consecutive cycles, j=0..3, then → DRAIN.
  - DRAIN: issue=0. When the writeback counter reaches 4:
    - if stage<2: stage+1, counter cleared, → ISSUE;
    - if stage==2: → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE. Stage returns to 0.
- Writeback counting:
  - wb_valid is counted in any non-IDLE state, 3-bit counter, saturating at 4.
  - A wb_valid received in IDLE sets err and is otherwise ignored.
- Address generation, with half=1<<stage, k=j&(half−1), grp=j>>stage:
  - a = grp·2·half + k
  - b = a + half
  - tw = k<<(2−stage)
  - Resulting sequences:
    - stage 0: a=0,2,4,6; b=1,3,5,7; tw=0,0,0,0
    - stage 1: a=0,1,4,5; b=2,3,6,7; tw=0,2,0,2
    - stage 2: a=0,1,2,3; b=4,5,6,7; tw=0,1,2,3
- Twiddle ROM, W8^tw as (w_re, w_im):
  - tw=0: (3F800000, 00000000)
  - tw=1: (3F3504F3, BF3504F3)
  - tw=2: (00000000, BF800000)
  - tw=3: (BF3504F3, BF3504F3)
  - is_mj = (tw==2).
  - When issue=0, w_re, w_im, is_mj, a_now and b_now hold 0.
- Timing, with LAT = 1 + L_MUL + 2·L_ADD (butterfly issue-to-writeback latency):
  - Start sampled at edge of cycle T → issues in T+1..T+4.
  - Stage s issues begin at T+1+s·(4+LAT).
  - done is asserted at cycle T+3·(4+LAT)+1; T+37 with defaults.
- Boundary conditions:
  - start while busy or in DONE is ignored, with no restart.
  - A wb_valid in the same cycle as the stage transition is counted before the transition check.
  - If DRAIN lasts TIMEOUT cycles without reaching 4 writebacks: err=1, FSM → DONE (done still pulses) → IDLE.
  - More than 4 wb_valid in one stage sets err.
  - Reset mid-run aborts immediately. All outputs go to 0; no done pulse.

Test Plan:
- Nominal run, with the butterfly model at LAT=8: start pulse at T → issue high in T+1..4, T+13..16 and T+25..28; done only at T+37; err=0; busy high T+1..T+36.
- Address/twiddle check: log (a_now, b_now, w_re, w_im, is_mj) on each issue → 12 tuples match the stage table exactly; is_mj=1 only on stage-1 j=1,3 and stage-2 j=2.
- Stall: withhold the 4th wb_valid of stage 1 for 20 extra cycles → stage 2 issue delayed by exactly 20 cycles; err=0.
- Timeout: drop the 4th wb_valid of stage 0 → err=1 after 64 DRAIN cycles, done pulses, FSM returns to IDLE; the next start clears err.
- Start ignored and spurious wb: start pulsed at T+5 and during DONE → no effect on the sequence; a wb_valid injected in IDLE → err=1.
- Reset mid-run: assert rst_n=0 during stage 1 issue → all outputs 0 asynchronously; after release, start runs a full clean transform.
